// File: rtl/nes_bus_pkg.sv
// rtl/nes_bus_pkg.sv - CPU-side bus addresses and sprite DMA state encoding
package nes_bus_pkg;

    localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
    localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_ACK = 3'd1,
        ST_DUMMY    = 3'd2,
        ST_ALIGN    = 3'd3,
        ST_READ     = 3'd4,
        ST_WRITE    = 3'd5
    } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - $4014 sprite DMA master: halts the CPU and copies one page into OAM via $2004
module oam_dma
    import nes_bus_pkg::*;
#(
    parameter int SRC_BYTES = 256
) (
    input  logic        i_cpu_clk,
    input  logic        i_cpu_rst,
    input  logic [15:0] i_bus_addr,
    input  logic        i_bus_wn,
    input  logic [7:0]  i_bus_wdata,
    input  logic [7:0]  i_mem_rdata,
    input  logic        i_halt_ack,
    output logic        o_halt_req,
    output logic        o_dma_active,
    output logic [15:0] o_dma_addr,
    output logic        o_dma_wn,
    output logic [7:0]  o_dma_wdata
);

    localparam logic [7:0] LAST_IDX = 8'(SRC_BYTES - 1);

    dma_state_t state;
    dma_state_t state_next;

    logic [7:0] r_page;
    logic [7:0] r_idx;
    logic [7:0] r_byte;
    logic       r_parity;
    logic       r_halt_req;
    logic       r_active;
    logic       trigger;

    assign trigger = (state == ST_IDLE) && (i_bus_addr == ADDR_OAMDMA) && !i_bus_wn;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (trigger) state_next = ST_WAIT_ACK;
            ST_WAIT_ACK: if (i_halt_ack) state_next = ST_DUMMY;
            // Odd-parity DUMMY lets READ start on an even cycle; otherwise burn one ALIGN cycle.
            ST_DUMMY:    state_next = r_parity ? ST_READ : ST_ALIGN;
            ST_ALIGN:    state_next = ST_READ;
            ST_READ:     state_next = ST_WRITE;
            ST_WRITE:    state_next = (r_idx == LAST_IDX) ? ST_IDLE : ST_READ;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_cpu_clk or posedge i_cpu_rst) begin
        if (i_cpu_rst) begin
            state      <= ST_IDLE;
            r_page     <= 8'h00;
            r_idx      <= 8'h00;
            r_byte     <= 8'h00;
            r_parity   <= 1'b0;
            r_halt_req <= 1'b0;
            r_active   <= 1'b0;
        end else begin
            state      <= state_next;
            r_parity   <= ~r_parity;
            r_halt_req <= (state_next != ST_IDLE);
            r_active   <= (state_next == ST_DUMMY) || (state_next == ST_ALIGN) ||
                          (state_next == ST_READ)  || (state_next == ST_WRITE);
            if (trigger) begin
                r_page <= i_bus_wdata;
                r_idx  <= 8'h00;
            end
            if (state == ST_READ) begin
                r_byte <= i_mem_rdata;
            end
            if ((state == ST_WRITE) && (r_idx != LAST_IDX)) begin
                r_idx <= r_idx + 8'h01;
            end
        end
    end

    // Bus fields decode combinationally so address and data are valid in the owning cycle.
    always_comb begin
        o_dma_addr  = 16'h0000;
        o_dma_wn    = 1'b1;
        o_dma_wdata = 8'h00;
        case (state)
            ST_DUMMY,
            ST_ALIGN: o_dma_addr = ADDR_OAMDMA;
            ST_READ:  o_dma_addr = {r_page, r_idx};
            ST_WRITE: begin
                o_dma_addr  = ADDR_OAMDATA;
                o_dma_wn    = 1'b0;
                o_dma_wdata = r_byte;
            end
            default: ;
        endcase
    end

    assign o_halt_req   = r_halt_req;
    assign o_dma_active = r_active;

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - randomized self-checking bench for oam_dma against a transaction-level model
module tb_oam_dma;

    logic        clk;
    logic        rst;
    logic [15:0] bus_addr;
    logic        bus_wn;
    logic [7:0]  bus_wdata;
    logic [7:0]  mem_rdata;
    logic        halt_ack;
    logic        halt_req;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic        dma_wn;
    logic [7:0]  dma_wdata;

    logic [7:0]  mem [65536];
    int          cyc;
    int          n_checks;
    int          n_pass;

    oam_dma #(.SRC_BYTES(256)) dut (
        .i_cpu_clk    (clk),
        .i_cpu_rst    (rst),
        .i_bus_addr   (bus_addr),
        .i_bus_wn     (bus_wn),
        .i_bus_wdata  (bus_wdata),
        .i_mem_rdata  (mem_rdata),
        .i_halt_ack   (halt_ack),
        .o_halt_req   (halt_req),
        .o_dma_active (dma_active),
        .o_dma_addr   (dma_addr),
        .o_dma_wn     (dma_wn),
        .o_dma_wdata  (dma_wdata)
    );

    assign mem_rdata = mem[dma_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle number since reset release; its LSB is the cycle parity.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic bus_idle();
        bus_addr  = 16'h0000;
        bus_wn    = 1'b1;
        bus_wdata = 8'h00;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_halt"},   32'(halt_req),   32'd0);
        chk({tag, "_active"}, 32'(dma_active), 32'd0);
        chk({tag, "_addr"},   32'(dma_addr),   32'h0000);
        chk({tag, "_wn"},     32'(dma_wn),     32'd1);
        chk({tag, "_wdata"},  32'(dma_wdata),  32'h00);
    endtask

    // Called at a negedge with the DUT idle. Returns at the negedge of the first IDLE cycle.
    task automatic run_dma(input logic [7:0] page, input int ack_dly, input bit pre_ack,
                           input int inj_at, input int rst_at);
        int rd_n, wr_n, bad_rd, bad_wr, idle_n, act_n, odd_rd;
        int first_act, last_wr, drop_cyc, dummy_cyc;
        bit done, aborted, align;
        logic [15:0] a;
        rd_n = 0; wr_n = 0; bad_rd = 0; bad_wr = 0; idle_n = 0; act_n = 0; odd_rd = 0;
        first_act = -1; last_wr = -1; drop_cyc = -1;
        done = 1'b0; aborted = 1'b0;

        halt_ack  = pre_ack;
        bus_addr  = 16'h4014;
        bus_wn    = 1'b0;
        bus_wdata = page;
        @(negedge clk);
        chk("halt_rise", 32'(halt_req), 32'd1);
        bus_idle();
        if (!pre_ack) begin
            repeat (ack_dly) @(negedge clk);
            halt_ack = 1'b1;
        end
        dummy_cyc = cyc + 1;
        align = ((dummy_cyc % 2) == 0);

        for (int n = 0; n < 1200 && !done && !aborted; n++) begin
            @(negedge clk);
            if (n == inj_at) begin
                bus_addr = 16'h4014; bus_wn = 1'b0; bus_wdata = 8'h07;
            end else begin
                bus_idle();
            end
            a = dma_addr;
            if (dma_active) begin
                act_n++;
                if (first_act < 0) first_act = cyc;
                if (!dma_wn) begin
                    if (a != 16'h2004 || dma_wdata != mem[{page, wr_n[7:0]}]) bad_wr++;
                    wr_n++;
                    last_wr = cyc;
                    if (wr_n == rst_at) begin
                        rst = 1'b1;
                        #1;
                        check_reset_outputs("rst_mid");
                        @(negedge clk);
                        rst = 1'b0;
                        halt_ack = 1'b0;
                        bus_idle();
                        aborted = 1'b1;
                    end
                end else if (a == 16'h4014 && rd_n == 0) begin
                    idle_n++;
                end else begin
                    if (a != {page, rd_n[7:0]}) bad_rd++;
                    if ((cyc % 2) != 0) odd_rd++;
                    rd_n++;
                end
            end else if (!halt_req) begin
                done = 1'b1;
                drop_cyc = cyc;
            end
        end

        if (!aborted) begin
            chk("done",        32'(done),      32'd1);
            chk("read_count",  32'(rd_n),      32'd256);
            chk("write_count", 32'(wr_n),      32'd256);
            chk("read_addr",   32'(bad_rd),    32'd0);
            chk("write_data",  32'(bad_wr),    32'd0);
            chk("read_parity", 32'(odd_rd),    32'd0);
            chk("dummy_cycle", 32'(first_act), 32'(dummy_cyc));
            chk("idle_cycles", 32'(idle_n),    32'(align ? 2 : 1));
            chk("active_len",  32'(act_n),     32'(align ? 514 : 513));
            chk("halt_drop",   32'(drop_cyc),  32'(last_wr + 1));
            halt_ack = 1'b0;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        halt_ack = 1'b0;
        bus_idle();
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_dma(8'h02, 3, 1'b0, -1, -1);
        run_dma(8'h02, 2, 1'b0, -1, -1);
        for (int k = 0; k < 4; k++) begin
            run_dma(8'($urandom), int'($urandom_range(0, 5)), 1'b0, -1, -1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        run_dma(8'h20, 1, 1'b0, -1, -1);
        run_dma(8'h02, 1, 1'b0, 60, -1);
        run_dma(8'h02, 3, 1'b0, -1, 100);
        run_dma(8'h03, 2, 1'b0, -1, -1);
        run_dma(8'hFF, 4, 1'b0, -1, -1);
        run_dma(8'($urandom), 0, 1'b1, -1, -1);
        run_dma(8'h02, 0, 1'b1, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
